// File: rtl/mix_columns_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_stream
//  Purpose  : Streaming AES MixColumns / InvMixColumns engine, LANES columns
//             per beat, batch-controlled with valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module mix_columns_stream #(
    parameter int LANES       = 1,
    parameter int PIPE_STAGES = 2,
    parameter int LEN_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  mode,
    input  logic [LEN_W-1:0]      length,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*32-1:0]   out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int c_W    = LANES * 32;
    localparam int c_LAST = PIPE_STAGES - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_mode;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_in_cnt;
    logic [LEN_W-1:0]   r_out_cnt;
    logic               r_done;

    logic [PIPE_STAGES-1:0] r_vld;
    logic [c_W-1:0]         r_dat [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] w_load;
    logic [PIPE_STAGES-1:0] w_src_vld;
    logic [c_W-1:0]         w_src_dat [PIPE_STAGES];
    logic [c_W-1:0]         w_xf;
    logic                   w_acc;
    logic                   w_in_hs;
    logic                   w_out_hs;
    logic [LEN_W-1:0]       w_in_nxt;
    logic [LEN_W-1:0]       w_out_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // t[k][c] holds the row-relative coefficient k applied to byte c
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  x1, x2, x4, x8;
        logic [7:0]  t [4][4];
        logic [31:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            x1 = col[8*c +: 8];
            x2 = xtime(x1);
            x4 = xtime(x2);
            x8 = xtime(x4);
            if (inv) begin
                t[0][c] = x8 ^ x4 ^ x2;
                t[1][c] = x8 ^ x2 ^ x1;
                t[2][c] = x8 ^ x4 ^ x1;
                t[3][c] = x8 ^ x1;
            end else begin
                t[0][c] = x2;
                t[1][c] = x2 ^ x1;
                t[2][c] = x1;
                t[3][c] = x1;
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                res[8*r +: 8] = res[8*r +: 8] ^ t[2'(c - r)][c];
            end
        end
        return res;
    endfunction

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_xf[32*k +: 32] = mix_col(in_data[32*k +: 32], r_mode);
    end

    // A stage may load if it or any stage downstream of it has room to move
    always_comb begin
        w_load = '0;
        w_acc  = out_ready;
        for (int i = c_LAST; i >= 0; i--) begin
            w_acc     = w_acc || !r_vld[i];
            w_load[i] = w_acc;
        end
    end

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_src
        if (i == 0) begin : g_head
            assign w_src_vld[i] = w_in_hs;
            assign w_src_dat[i] = w_xf;
        end else begin : g_tail
            assign w_src_vld[i] = r_vld[i-1];
            assign w_src_dat[i] = r_dat[i-1];
        end
    end

    assign in_ready  = (r_state == S_RUN) && (r_in_cnt < r_len) && w_load[0];
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = r_vld[c_LAST] && out_ready;
    assign w_in_nxt  = r_in_cnt + LEN_W'(1);
    assign w_out_nxt = r_out_cnt + LEN_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (w_load[i]) begin
                    r_vld[i] <= w_src_vld[i];
                    if (w_src_vld[i]) begin
                        r_dat[i] <= w_src_dat[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_mode    <= 1'b0;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_mode    <= mode;
                        r_len     <= length;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        if (length != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (w_in_hs) begin
                        r_in_cnt <= w_in_nxt;
                        if (w_in_nxt == r_len) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    if (w_out_hs) begin
                        r_out_cnt <= w_out_nxt;
                        if (w_out_nxt == r_len) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = r_vld[c_LAST];
    assign out_data  = r_dat[c_LAST];
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule
`default_nettype wire
